// File: rtl/i2s_pcm_player.sv
// rtl/i2s_pcm_player.sv - SDRAM-fed PCM sample FIFO driving an I2S serial data output
// Fetch FSM fills the FIFO; the player pops one word per channel slot from the codec clocks.
module i2s_pcm_player #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  input  logic [24:0] start_addr,
  input  logic [24:0] num_words,
  input  logic        I2S_sdram_Wait,
  input  logic        I2S_sdram_ac,
  input  logic [15:0] I2S_sdram_data,
  output logic        I2S_sdram_rd,
  output logic [24:0] I2S_sdram_addr,
  output logic        I2S_Busy,
  output logic        I2S_Done,
  input  logic        I2S_SCLK,
  input  logic        I2S_LRCLK,
  output logic        I2S_DOUT,
  output logic        playing,
  output logic        underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_GRANT, READ, DONE} state_t;

  state_t        state, state_next;
  logic [24:0]   remaining;
  logic          fetch_end;
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          sclk_s1, sclk_s2, sclk_s3;
  logic          lrclk_s1, lrclk_s2, lr_prev;
  logic [15:0]   shift;

  logic sclk_fall, ch_start, push, pop, last_word, start_ok;

  assign sclk_fall  = sclk_s3 & ~sclk_s2;
  assign ch_start   = sclk_fall && (lrclk_s2 != lr_prev);
  assign push       = (state == READ) && I2S_sdram_ac && !stop;
  assign pop        = ch_start && (count != '0) && playing && !stop;
  assign count_next = count + CW'(push) - CW'(pop);
  assign last_word  = (remaining == 25'd1);
  assign start_ok   = (state == IDLE) && start && !stop && (num_words != 25'd0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_ok) state_next = WAIT_GRANT;
      WAIT_GRANT: begin
        if (stop)
          state_next = I2S_sdram_Wait ? IDLE : DONE;
        else if (!I2S_sdram_Wait)
          state_next = (count < DEPTH_C && !fetch_end) ? READ : DONE;
      end
      READ: begin
        if (stop)
          state_next = I2S_sdram_Wait ? IDLE : DONE;
        else if (I2S_sdram_ac)
          state_next = (count_next == DEPTH_C || (last_word && !loop)) ? DONE : READ;
        else if (I2S_sdram_Wait)
          state_next = WAIT_GRANT;
      end
      DONE: state_next = (stop || (fetch_end && count == '0)) ? IDLE : WAIT_GRANT;
      default: state_next = IDLE;
    endcase
  end

  // A revoked grant drops the request in the same cycle; the address is simply re-requested.
  always_comb begin
    I2S_sdram_rd = 1'b0;
    I2S_Busy     = 1'b0;
    I2S_Done     = 1'b0;
    case (state)
      READ: begin
        I2S_sdram_rd = !I2S_sdram_Wait || I2S_sdram_ac;
        I2S_Busy     = 1'b1;
      end
      DONE:    I2S_Done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= I2S_sdram_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else if (stop) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1  <= 1'b0;
      sclk_s2  <= 1'b0;
      sclk_s3  <= 1'b0;
      lrclk_s1 <= 1'b0;
      lrclk_s2 <= 1'b0;
    end else begin
      sclk_s1  <= I2S_SCLK;
      sclk_s2  <= sclk_s1;
      sclk_s3  <= sclk_s2;
      lrclk_s1 <= I2S_LRCLK;
      lrclk_s2 <= lrclk_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      I2S_sdram_addr <= '0;
      remaining      <= '0;
      fetch_end      <= 1'b0;
      playing        <= 1'b0;
      underflow      <= 1'b0;
      lr_prev        <= 1'b0;
      shift          <= '0;
      I2S_DOUT       <= 1'b0;
    end else begin
      if (ch_start) begin
        lr_prev <= lrclk_s2;
        shift   <= pop ? fifo_mem[rd_ptr] : 16'h0000;
        if (count == '0 && playing) begin
          if (fetch_end) playing   <= 1'b0;
          else           underflow <= 1'b1;
        end
      end else if (sclk_fall) begin
        I2S_DOUT <= shift[15];
        shift    <= {shift[14:0], 1'b0};
      end

      if (push) begin
        if (last_word && loop) begin
          I2S_sdram_addr <= start_addr;
          remaining      <= num_words;
        end else begin
          I2S_sdram_addr <= I2S_sdram_addr + 25'd1;
          remaining      <= remaining - 25'd1;
          if (last_word) fetch_end <= 1'b1;
        end
      end

      if (start_ok) begin
        I2S_sdram_addr <= start_addr;
        remaining      <= num_words;
        fetch_end      <= 1'b0;
        playing        <= 1'b1;
        underflow      <= 1'b0;
      end

      // Marking the fetch finished lets DONE fall through to IDLE once the flushed FIFO reads empty.
      if (stop) begin
        playing   <= 1'b0;
        fetch_end <= 1'b1;
        shift     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_pcm_player.sv
// tb/tb_i2s_pcm_player.sv - directed self-checking bench for i2s_pcm_player
module tb_i2s_pcm_player;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [24:0] start_addr = '0, num_words = '0;
  logic        I2S_sdram_Wait = 1'b0, I2S_sdram_ac = 1'b0;
  logic [15:0] I2S_sdram_data = '0;
  logic        I2S_sdram_rd;
  logic [24:0] I2S_sdram_addr;
  logic        I2S_Busy, I2S_Done;
  logic        I2S_SCLK = 1'b0, I2S_LRCLK = 1'b0;
  logic        I2S_DOUT, playing, underflow;

  int          n_cmp = 0, n_bad = 0;
  int          ac_count = 0, base = 0;
  logic        resp_en = 1'b1;
  logic [24:0] addr_log [0:63];

  i2s_pcm_player #(.FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
    .start_addr(start_addr), .num_words(num_words),
    .I2S_sdram_Wait(I2S_sdram_Wait), .I2S_sdram_ac(I2S_sdram_ac),
    .I2S_sdram_data(I2S_sdram_data), .I2S_sdram_rd(I2S_sdram_rd),
    .I2S_sdram_addr(I2S_sdram_addr), .I2S_Busy(I2S_Busy), .I2S_Done(I2S_Done),
    .I2S_SCLK(I2S_SCLK), .I2S_LRCLK(I2S_LRCLK), .I2S_DOUT(I2S_DOUT),
    .playing(playing), .underflow(underflow)
  );

  always #10 clk = ~clk;

  function automatic logic [15:0] data_of(input logic [24:0] a);
    if (a == 25'h200)      return 16'hA5C3;
    else if (a == 25'h201) return 16'h0001;
    else                   return a[15:0] ^ 16'h1234;
  endfunction

  // SDRAM model: acknowledges each request one cycle after it is raised.
  always @(negedge clk) begin
    if (resp_en && I2S_sdram_rd && !I2S_sdram_ac && !I2S_sdram_Wait) begin
      I2S_sdram_ac   = 1'b1;
      I2S_sdram_data = data_of(I2S_sdram_addr);
      if (ac_count < 64) addr_log[ac_count] = I2S_sdram_addr;
      ac_count = ac_count + 1;
    end else begin
      I2S_sdram_ac = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_bad = n_bad + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    base = ac_count;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  task automatic sclk_pulse(input logic lr);
    I2S_LRCLK = lr;
    I2S_SCLK  = 1'b1;
    tick(8);
    I2S_SCLK  = 1'b0;
    tick(8);
  endtask

  task automatic wait_acs(input int target, input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick(1);
      if (ac_count - base >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  logic        ok;
  logic [15:0] pat;

  initial begin
    tick(1);
    do_reset();
    check("rst_rd", 32'(I2S_sdram_rd), 32'd0);
    check("rst_busy", 32'(I2S_Busy), 32'd0);
    check("rst_done", 32'(I2S_Done), 32'd0);
    check("rst_dout", 32'(I2S_DOUT), 32'd0);
    check("rst_playing", 32'(playing), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_addr", 32'(I2S_sdram_addr), 32'd0);

    // Zero-length start is ignored; start+stop together leaves playback off.
    num_words = 25'd0;
    pulse_start();
    tick(2);
    check("zero_len_playing", 32'(playing), 32'd0);
    check("zero_len_rd", 32'(I2S_sdram_rd), 32'd0);
    num_words = 25'd4;
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    tick(2);
    check("start_stop_playing", 32'(playing), 32'd0);
    check("start_stop_acs", 32'(ac_count - base), 32'd0);

    // Four-word fetch.
    do_reset();
    start_addr = 25'h100; num_words = 25'd4; loop = 1'b0;
    pulse_start();
    check("fetch4_playing", 32'(playing), 32'd1);
    wait_acs(4, 50, ok);
    check("fetch4_timeout", 32'(ok), 32'd1);
    check("fetch4_done", 32'(I2S_Done), 32'd1);
    check("fetch4_rd_after", 32'(I2S_sdram_rd), 32'd0);
    check("fetch4_fetch_end", 32'(dut.fetch_end), 32'd1);
    for (int i = 0; i < 4; i++)
      check($sformatf("fetch4_addr%0d", i), 32'(addr_log[base + i]), 32'h100 + 32'(i));
    tick(1);
    check("fetch4_done_one_cycle", 32'(I2S_Done), 32'd0);
    check("fetch4_acs_total", 32'(ac_count - base), 32'd4);

    // FIFO-limited fetch, resumed by pops.
    do_reset();
    start_addr = 25'h0; num_words = 25'd40;
    pulse_start();
    tick(100);
    check("fill_acs", 32'(ac_count - base), 32'd16);
    check("fill_busy", 32'(I2S_Busy), 32'd0);
    sclk_pulse(1'b1);
    sclk_pulse(1'b0);
    tick(20);
    check("refill_acs", 32'(ac_count - base), 32'd18);
    check("refill_underflow", 32'(underflow), 32'd0);
    pulse_stop();

    // Looping address sequence.
    do_reset();
    start_addr = 25'h10; num_words = 25'd2; loop = 1'b1;
    pulse_start();
    tick(40);
    for (int i = 0; i < 6; i++)
      check($sformatf("loop_addr%0d", i), 32'(addr_log[base + i]), 32'h10 + 32'(i % 2));
    check("loop_playing", 32'(playing), 32'd1);
    loop = 1'b0;
    pulse_stop();

    // Serial output of L=A5C3, R=0001.
    do_reset();
    I2S_LRCLK = 1'b1;
    sclk_pulse(1'b1);
    sclk_pulse(1'b1);
    start_addr = 25'h200; num_words = 25'd2;
    pulse_start();
    tick(20);
    check("ser_acs", 32'(ac_count - base), 32'd2);
    sclk_pulse(1'b0);
    pat = 16'hA5C3;
    for (int i = 15; i >= 0; i--) begin
      sclk_pulse(1'b0);
      check($sformatf("ser_left_bit%0d", i), 32'(I2S_DOUT), 32'(pat[i]));
    end
    sclk_pulse(1'b1);
    pat = 16'h0001;
    for (int i = 15; i >= 0; i--) begin
      sclk_pulse(1'b1);
      check($sformatf("ser_right_bit%0d", i), 32'(I2S_DOUT), 32'(pat[i]));
    end
    sclk_pulse(1'b0);
    sclk_pulse(1'b0);
    check("ser_tail_zero", 32'(I2S_DOUT), 32'd0);
    check("ser_end_playing", 32'(playing), 32'd0);
    check("ser_end_underflow", 32'(underflow), 32'd0);
    check("ser_end_done", 32'(I2S_Done), 32'd0);

    // Port never granted: underrun.
    do_reset();
    I2S_LRCLK = 1'b0;
    I2S_sdram_Wait = 1'b1;
    start_addr = 25'h300; num_words = 25'd8;
    pulse_start();
    sclk_pulse(1'b1);
    sclk_pulse(1'b1);
    sclk_pulse(1'b0);
    sclk_pulse(1'b0);
    check("uf_underflow", 32'(underflow), 32'd1);
    check("uf_dout", 32'(I2S_DOUT), 32'd0);
    check("uf_rd", 32'(I2S_sdram_rd), 32'd0);
    check("uf_acs", 32'(ac_count - base), 32'd0);
    check("uf_playing", 32'(playing), 32'd1);
    I2S_sdram_Wait = 1'b0;
    pulse_stop();
    tick(3);
    check("uf_sticky", 32'(underflow), 32'd1);

    // Stop during READ.
    do_reset();
    resp_en = 1'b0;
    start_addr = 25'h400; num_words = 25'd8;
    pulse_start();
    tick(1);
    check("stop_pre_rd", 32'(I2S_sdram_rd), 32'd1);
    check("stop_pre_busy", 32'(I2S_Busy), 32'd1);
    check("stop_pre_addr", 32'(I2S_sdram_addr), 32'h400);
    pulse_stop();
    check("stop_rd", 32'(I2S_sdram_rd), 32'd0);
    check("stop_done", 32'(I2S_Done), 32'd1);
    check("stop_playing", 32'(playing), 32'd0);
    tick(1);
    check("stop_idle_done", 32'(I2S_Done), 32'd0);
    check("stop_idle_busy", 32'(I2S_Busy), 32'd0);
    tick(3);
    check("stop_no_more_done", 32'(I2S_Done), 32'd0);
    check("stop_no_rd", 32'(I2S_sdram_rd), 32'd0);
    resp_en = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
